// File: rtl/rv32i_decode_execute_if.sv
// rv32i_decode_execute_if: fetch/regfile-facing signals of the decode/execute stage.
// illegal_o exists only when ILLEGAL_INSN_DETECT_EN is defined.
interface rv32i_decode_execute_if #(
  parameter int AWIDTH = 32,
  parameter int DWIDTH = 32
);
  logic [31:0]       insn_i;
  logic [AWIDTH-1:0] pc_i;
  logic [DWIDTH-1:0] rs1data_i;
  logic [DWIDTH-1:0] rs2data_i;
  logic [AWIDTH-1:0] pc_o;
  logic [31:0]       insn_o;
  logic [6:0]        opcode_o;
  logic [4:0]        rd_o;
  logic [4:0]        rs1_o;
  logic [4:0]        rs2_o;
  logic [2:0]        funct3_o;
  logic [6:0]        funct7_o;
  logic [4:0]        shamt_o;
  logic [31:0]       imm_o;
  logic              pcsel_o;
  logic              immsel_o;
  logic              regwren_o;
  logic              rs1sel_o;
  logic              rs2sel_o;
  logic              memren_o;
  logic              memwren_o;
  logic              jump_o;
  logic              branch_o;
  logic [1:0]        wbsel_o;
  logic [3:0]        alusel_o;
  logic [DWIDTH-1:0] res_o;
  logic              brtaken_o;
`ifdef ILLEGAL_INSN_DETECT_EN
  logic              illegal_o;
`endif
  modport master (
`ifdef ILLEGAL_INSN_DETECT_EN
    input illegal_o,
`endif
    output insn_i, pc_i, rs1data_i, rs2data_i,
    input pc_o, insn_o, opcode_o, rd_o, rs1_o, rs2_o, funct3_o, funct7_o, shamt_o, imm_o,
    input pcsel_o, immsel_o, regwren_o, rs1sel_o, rs2sel_o, memren_o, memwren_o, jump_o,
    input branch_o, wbsel_o, alusel_o, res_o, brtaken_o
  );
  modport slave (
`ifdef ILLEGAL_INSN_DETECT_EN
    output illegal_o,
`endif
    input insn_i, pc_i, rs1data_i, rs2data_i,
    output pc_o, insn_o, opcode_o, rd_o, rs1_o, rs2_o, funct3_o, funct7_o, shamt_o, imm_o,
    output pcsel_o, immsel_o, regwren_o, rs1sel_o, rs2sel_o, memren_o, memwren_o, jump_o,
    output branch_o, wbsel_o, alusel_o, res_o, brtaken_o
  );
endinterface

// File: rtl/rv32i_decode_execute.sv
// rv32i_decode_execute: registered-instruction RV32I decode, control, ALU and branch compare.
// Defining ILLEGAL_INSN_DETECT_EN adds illegal_o for unrecognised/reserved encodings.
module rv32i_decode_execute #(
  parameter int AWIDTH = 32,
  parameter int DWIDTH = 32,
  parameter logic [AWIDTH-1:0] BASEADDR = 32'h01000000
) (
  input logic clk,
  input logic rst,
  rv32i_decode_execute_if.slave bus
);
  localparam logic [6:0] OP_R = 7'h33, OP_I = 7'h13, OP_LD = 7'h03, OP_ST = 7'h23, OP_BR = 7'h63;
  localparam logic [6:0] OP_JAL = 7'h6F, OP_JALR = 7'h67, OP_LUI = 7'h37, OP_AUIPC = 7'h17;
  logic [31:0] insn;
  logic [AWIDTH-1:0] pc;
  logic [6:0] op;
  logic [2:0] f3;
  logic [31:0] imm;
  logic regwren, memren, memwren, rs1sel, rs2sel, jump, branch, immsel, known, alt, cond;
  logic [1:0] wbsel;
  logic [3:0] arith, alusel;
  logic [DWIDTH-1:0] a, b, alu;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      insn <= 32'h00000013;
      pc <= BASEADDR;
    end else begin
      insn <= bus.insn_i;
      pc <= bus.pc_i;
    end
  assign op = insn[6:0];
  assign f3 = insn[14:12];
  always_comb begin
    case (op)
      OP_I, OP_LD, OP_JALR: imm = {{20{insn[31]}}, insn[31:20]};
      OP_ST:                imm = {{20{insn[31]}}, insn[31:25], insn[11:7]};
      OP_BR:                imm = {{20{insn[31]}}, insn[7], insn[30:25], insn[11:8], 1'b0};
      OP_LUI, OP_AUIPC:     imm = {insn[31:12], 12'b0};
      OP_JAL:               imm = {{12{insn[31]}}, insn[19:12], insn[20], insn[30:21], 1'b0};
      default:              imm = '0;
    endcase
  end
  always_comb begin
    {regwren, memren, memwren, rs1sel, rs2sel, jump, branch, immsel} = '0;
    wbsel = 2'd0;
    known = 1'b1;
    case (op)
      OP_R:     regwren = 1'b1;
      OP_I:     {regwren, rs2sel, immsel} = '1;
      OP_LD:    begin {regwren, memren, rs2sel, immsel} = '1; wbsel = 2'd1; end
      OP_ST:    {memwren, rs2sel, immsel} = '1;
      OP_BR:    {rs1sel, rs2sel, branch, immsel} = '1;
      OP_JAL:   begin {regwren, rs1sel, rs2sel, jump, immsel} = '1; wbsel = 2'd2; end
      OP_JALR:  begin {regwren, rs2sel, jump, immsel} = '1; wbsel = 2'd2; end
      OP_LUI:   {regwren, rs2sel, immsel} = '1;
      OP_AUIPC: {regwren, rs1sel, rs2sel, immsel} = '1;
      default:  known = 1'b0;
    endcase
  end
  // I-type only honours funct7[5] as the SRAI selector; SUB is R-type only
  assign alt = (op == OP_R) ? insn[30] : (f3 == 3'b101) & insn[30];
  always_comb begin
    case (f3)
      3'b000:  arith = alt ? 4'd1 : 4'd0;
      3'b001:  arith = 4'd2;
      3'b010:  arith = 4'd3;
      3'b011:  arith = 4'd4;
      3'b100:  arith = 4'd5;
      3'b101:  arith = alt ? 4'd7 : 4'd6;
      3'b110:  arith = 4'd8;
      default: arith = 4'd9;
    endcase
  end
  assign alusel = (op == OP_R || op == OP_I) ? arith : (op == OP_LUI) ? 4'd10 : 4'd0;
  assign a = rs1sel ? DWIDTH'(pc) : bus.rs1data_i;
  assign b = rs2sel ? DWIDTH'(imm) : bus.rs2data_i;
  always_comb begin
    case (alusel)
      4'd1:    alu = a - b;
      4'd2:    alu = a << b[4:0];
      4'd3:    alu = DWIDTH'($signed(a) < $signed(b));
      4'd4:    alu = DWIDTH'(a < b);
      4'd5:    alu = a ^ b;
      4'd6:    alu = a >> b[4:0];
      4'd7:    alu = $signed(a) >>> b[4:0];
      4'd8:    alu = a | b;
      4'd9:    alu = a & b;
      4'd10:   alu = b;
      default: alu = a + b;
    endcase
  end
  always_comb begin
    case (f3)
      3'b000:  cond = bus.rs1data_i == bus.rs2data_i;
      3'b001:  cond = bus.rs1data_i != bus.rs2data_i;
      3'b100:  cond = $signed(bus.rs1data_i) < $signed(bus.rs2data_i);
      3'b101:  cond = $signed(bus.rs1data_i) >= $signed(bus.rs2data_i);
      3'b110:  cond = bus.rs1data_i < bus.rs2data_i;
      3'b111:  cond = bus.rs1data_i >= bus.rs2data_i;
      default: cond = 1'b0;
    endcase
  end
  assign bus.insn_o = insn;
  assign bus.pc_o = pc;
  assign bus.opcode_o = op;
  assign bus.rd_o = insn[11:7];
  assign bus.funct3_o = f3;
  assign bus.rs1_o = insn[19:15];
  assign bus.rs2_o = insn[24:20];
  assign bus.shamt_o = insn[24:20];
  assign bus.funct7_o = insn[31:25];
  assign bus.imm_o = imm;
  assign bus.regwren_o = regwren;
  assign bus.memren_o = memren;
  assign bus.memwren_o = memwren;
  assign bus.rs1sel_o = rs1sel;
  assign bus.rs2sel_o = rs2sel;
  assign bus.jump_o = jump;
  assign bus.branch_o = branch;
  assign bus.immsel_o = immsel;
  assign bus.wbsel_o = wbsel;
  assign bus.alusel_o = alusel;
  assign bus.brtaken_o = (op == OP_BR) & cond;
  assign bus.pcsel_o = jump | (branch & bus.brtaken_o);
  assign bus.res_o = !known ? '0 : (op == OP_JALR) ? {alu[DWIDTH-1:1], 1'b0} : alu;
`ifdef ILLEGAL_INSN_DETECT_EN
  assign bus.illegal_o = !known | (op == OP_BR && f3[2:1] == 2'b01) |
                         (op == OP_R && insn[31:25] != 7'h00 && insn[31:25] != 7'h20);
`endif
endmodule

// File: tb/tb_rv32i_decode_execute.sv
// tb_rv32i_decode_execute: directed vector table, reset sequences and randomized
// instructions checked against an instruction-semantics reference model.
module tb_rv32i_decode_execute;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int tests = 0;
  int fails = 0;
  always #5 clk = ~clk;
  rv32i_decode_execute_if #(.AWIDTH(32), .DWIDTH(32)) bus ();
  rv32i_decode_execute dut (.clk(clk), .rst(rst), .bus(bus));

  typedef struct packed {
    logic [31:0] imm, res;
    logic [3:0]  alusel;
    logic [1:0]  wbsel;
    logic regwren, memren, memwren, rs1sel, rs2sel, jump, branch, immsel, brt, pcsel, ill;
  } exp_t;

  typedef struct {
    logic [31:0] insn, pc, a, b, res;
    logic brt, pcsel, ill;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] arith(input logic [2:0] f3, input logic alt, input logic [31:0] x, input logic [31:0] y);
    case (f3)
      3'd0: return alt ? x - y : x + y;
      3'd1: return x << y[4:0];
      3'd2: return {31'b0, $signed(x) < $signed(y)};
      3'd3: return {31'b0, x < y};
      3'd4: return x ^ y;
      3'd5: return alt ? 32'($signed(x) >>> y[4:0]) : x >> y[4:0];
      3'd6: return x | y;
      default: return x & y;
    endcase
  endfunction

  function automatic logic [3:0] opsel(input logic [2:0] f3, input logic alt);
    logic [31:0] base;
    base = 32'h9865_4320;
    if (alt && f3 == 3'd0) return 4'd1;
    if (alt && f3 == 3'd5) return 4'd7;
    return base[f3*4 +: 4];
  endfunction

  function automatic exp_t model(input logic [31:0] i, input logic [31:0] pc, input logic [31:0] a, input logic [31:0] b);
    exp_t e;
    logic [2:0] f3;
    logic [31:0] sx;
    logic alt;
    e = '0;
    f3 = i[14:12];
    sx = {{20{i[31]}}, i[31:20]};
    case (i[6:0])
      7'h33: begin
        e.regwren = 1; e.res = arith(f3, i[30], a, b); e.alusel = opsel(f3, i[30]);
        e.ill = i[31:25] != 7'h00 && i[31:25] != 7'h20;
      end
      7'h13: begin
        alt = (f3 == 3'd5) && i[30];
        e.regwren = 1; e.rs2sel = 1; e.immsel = 1; e.imm = sx;
        e.res = arith(f3, alt, a, sx); e.alusel = opsel(f3, alt);
      end
      7'h03: begin
        e.regwren = 1; e.memren = 1; e.rs2sel = 1; e.immsel = 1; e.wbsel = 1; e.imm = sx; e.res = a + sx;
      end
      7'h23: begin
        e.memwren = 1; e.rs2sel = 1; e.immsel = 1;
        e.imm = {{20{i[31]}}, i[31:25], i[11:7]}; e.res = a + e.imm;
      end
      7'h63: begin
        e.rs1sel = 1; e.rs2sel = 1; e.branch = 1; e.immsel = 1;
        e.imm = {{19{i[31]}}, i[31], i[7], i[30:25], i[11:8], 1'b0}; e.res = pc + e.imm;
        case (f3)
          3'd0: e.brt = a == b;
          3'd1: e.brt = a != b;
          3'd4: e.brt = $signed(a) < $signed(b);
          3'd5: e.brt = $signed(a) >= $signed(b);
          3'd6: e.brt = a < b;
          3'd7: e.brt = a >= b;
          default: e.ill = 1;
        endcase
        e.pcsel = e.brt;
      end
      7'h6F: begin
        e.regwren = 1; e.rs1sel = 1; e.rs2sel = 1; e.jump = 1; e.immsel = 1; e.wbsel = 2; e.pcsel = 1;
        e.imm = {{11{i[31]}}, i[31], i[19:12], i[20], i[30:21], 1'b0}; e.res = pc + e.imm;
      end
      7'h67: begin
        e.regwren = 1; e.rs2sel = 1; e.jump = 1; e.immsel = 1; e.wbsel = 2; e.pcsel = 1;
        e.imm = sx; e.res = (a + sx) & ~32'd1;
      end
      7'h37: begin
        e.regwren = 1; e.rs2sel = 1; e.immsel = 1; e.imm = {i[31:12], 12'h0}; e.res = e.imm; e.alusel = 10;
      end
      7'h17: begin
        e.regwren = 1; e.rs1sel = 1; e.rs2sel = 1; e.immsel = 1; e.imm = {i[31:12], 12'h0}; e.res = pc + e.imm;
      end
      default: e.ill = 1;
    endcase
    return e;
  endfunction

  task automatic apply(input logic [31:0] i, input logic [31:0] p, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    bus.insn_i = i;
    bus.pc_i = p;
    @(posedge clk);
    #1;
    bus.rs1data_i = a;
    bus.rs2data_i = b;
    #1;
  endtask

  task automatic check_all(input logic [31:0] i, input logic [31:0] p, input logic [31:0] a, input logic [31:0] b);
    exp_t e;
    e = model(i, p, a, b);
    check("insn", bus.insn_o, i);
    check("pc", bus.pc_o, p);
    check("fields", {bus.opcode_o, bus.rd_o, bus.funct3_o, bus.rs1_o, bus.rs2_o, bus.funct7_o},
          {i[6:0], i[11:7], i[14:12], i[19:15], i[24:20], i[31:25]});
    check("shamt", 32'(bus.shamt_o), 32'(i[24:20]));
    check("imm", bus.imm_o, e.imm);
    check("res", bus.res_o, e.res);
    check("alusel", 32'(bus.alusel_o), 32'(e.alusel));
    check("wbsel", 32'(bus.wbsel_o), 32'(e.wbsel));
    check("ctrl", {bus.regwren_o, bus.memren_o, bus.memwren_o, bus.rs1sel_o, bus.rs2sel_o, bus.jump_o, bus.branch_o, bus.immsel_o},
          {e.regwren, e.memren, e.memwren, e.rs1sel, e.rs2sel, e.jump, e.branch, e.immsel});
    check("brtaken", 32'(bus.brtaken_o), 32'(e.brt));
    check("pcsel", 32'(bus.pcsel_o), 32'(e.pcsel));
`ifdef ILLEGAL_INSN_DETECT_EN
    check("illegal", 32'(bus.illegal_o), 32'(e.ill));
`endif
  endtask

  vec_t vt[15];
  logic [6:0] ops[10] = '{7'h33, 7'h13, 7'h03, 7'h23, 7'h63, 7'h6F, 7'h67, 7'h37, 7'h17, 7'h73};

  initial begin
    vt[0]  = '{32'h00500093, 32'h01000000, 32'h0, 32'h0, 32'h00000005, 1'b0, 1'b0, 1'b0};
    vt[1]  = '{32'h40208133, 32'h01000004, 32'h7, 32'h9, 32'hFFFFFFFE, 1'b0, 1'b0, 1'b0};
    vt[2]  = '{32'hFE208EE3, 32'h01000010, 32'h3, 32'h3, 32'h0100000C, 1'b1, 1'b1, 1'b0};
    vt[3]  = '{32'hFE208EE3, 32'h01000010, 32'h3, 32'h4, 32'h0100000C, 1'b0, 1'b0, 1'b0};
    vt[4]  = '{32'h00008067, 32'h01000014, 32'h01000021, 32'h0, 32'h01000020, 1'b0, 1'b1, 1'b0};
    vt[5]  = '{32'h00000073, 32'h01000018, 32'h5, 32'h6, 32'h00000000, 1'b0, 1'b0, 1'b1};
    vt[6]  = '{32'h123452B7, 32'h0, 32'h0, 32'h0, 32'h12345000, 1'b0, 1'b0, 1'b0};
    vt[7]  = '{32'h40415093, 32'h0, 32'h80000000, 32'h0, 32'hF8000000, 1'b0, 1'b0, 1'b0};
    vt[8]  = '{32'hFE20CEE3, 32'h01000010, 32'hFFFFFFFF, 32'h1, 32'h0100000C, 1'b1, 1'b1, 1'b0};
    vt[9]  = '{32'hFE20EEE3, 32'h01000010, 32'hFFFFFFFF, 32'h1, 32'h0100000C, 1'b0, 1'b0, 1'b0};
    vt[10] = '{32'hFE20AEE3, 32'h01000010, 32'h3, 32'h3, 32'h0100000C, 1'b0, 1'b0, 1'b1};
    vt[11] = '{32'h00001097, 32'h01000004, 32'h0, 32'h0, 32'h01001004, 1'b0, 1'b0, 1'b0};
    vt[12] = '{32'h0020A423, 32'h0, 32'h100, 32'h55, 32'h00000108, 1'b0, 1'b0, 1'b0};
    vt[13] = '{32'h008000EF, 32'h01000000, 32'h0, 32'h0, 32'h01000008, 1'b0, 1'b1, 1'b0};
    vt[14] = '{32'h02208133, 32'h0, 32'h7, 32'h9, 32'h00000010, 1'b0, 1'b0, 1'b1};
    bus.insn_i = 32'hFE208EE3;
    bus.pc_i = 32'h0;
    bus.rs1data_i = 32'h1234;
    bus.rs2data_i = 32'h1234;
    #12;
    check("rst_insn", bus.insn_o, 32'h00000013);
    check("rst_pc", bus.pc_o, 32'h01000000);
    check("rst_brt_pcsel", {bus.brtaken_o, bus.pcsel_o}, 2'b00);
    check("rst_res", bus.res_o, 32'h1234);
    check("rst_op_rd_imm", {bus.opcode_o, bus.rd_o, bus.imm_o}, {7'h13, 5'd0, 32'd0});
    check("rst_regwren_alusel", {bus.regwren_o, bus.alusel_o}, {1'b1, 4'd0});
`ifdef ILLEGAL_INSN_DETECT_EN
    check("rst_illegal", 32'(bus.illegal_o), 32'd0);
`endif
    @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k < 15; k++) begin
      apply(vt[k].insn, vt[k].pc, vt[k].a, vt[k].b);
      check($sformatf("vec%0d_res", k), bus.res_o, vt[k].res);
      check($sformatf("vec%0d_brt_pcsel", k), {bus.brtaken_o, bus.pcsel_o}, {vt[k].brt, vt[k].pcsel});
`ifdef ILLEGAL_INSN_DETECT_EN
      check($sformatf("vec%0d_illegal", k), 32'(bus.illegal_o), 32'(vt[k].ill));
`endif
      check_all(vt[k].insn, vt[k].pc, vt[k].a, vt[k].b);
    end
    apply(32'h00500093, 32'h01000000, 32'h0, 32'h0);
    check("addi_rd_imm_wren", {bus.rd_o, bus.imm_o, bus.regwren_o}, {5'd1, 32'd5, 1'b1});
    apply(32'h40208133, 32'h01000004, 32'h7, 32'h9);
    check("sub_alusel", 32'(bus.alusel_o), 32'd1);
    apply(32'hFE208EE3, 32'h01000010, 32'h3, 32'h3);
    check("beq_imm", bus.imm_o, 32'hFFFFFFFC);
    bus.rs2data_i = 32'h4;
    #1;
    check("beq_comb_pcsel", 32'(bus.pcsel_o), 32'd0);
    apply(32'h00008067, 32'h01000014, 32'h01000021, 32'h0);
    check("jalr_jump_wbsel", {bus.jump_o, bus.wbsel_o, bus.pcsel_o}, {1'b1, 2'd2, 1'b1});
    apply(32'h00000073, 32'h01000018, 32'h5, 32'h6);
    check("ecall_ctrl", {bus.regwren_o, bus.memwren_o, bus.memren_o, bus.pcsel_o, bus.immsel_o}, 5'b0);
    // asynchronous reset mid-stream drops the held jump without waiting for an edge
    apply(32'h008000EF, 32'h01000000, 32'h0, 32'h0);
    #2;
    rst = 1'b1;
    #1;
    check("midrst_insn", bus.insn_o, 32'h00000013);
    check("midrst_pc_pcsel", {bus.pc_o, bus.pcsel_o}, {32'h01000000, 1'b0});
    @(negedge clk);
    rst = 1'b0;
    for (int n = 0; n < 400; n++) begin
      logic [31:0] r, i, p, a, b;
      logic [6:0] op;
      r = $urandom();
      op = ($urandom_range(10) == 10) ? 7'($urandom()) : ops[$urandom_range(9)];
      i = {r[31:7], op};
      if (op == 7'h33 && $urandom_range(3) != 0) i[31:25] = $urandom_range(1) ? 7'h20 : 7'h00;
      p = $urandom() & ~32'd3;
      a = $urandom();
      b = ($urandom_range(3) == 0) ? a : $urandom();
      apply(i, p, a, b);
      check_all(i, p, a, b);
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/rv32i_decode_execute.md
# rv32i_decode_execute

Single-cycle RV32I decode/control/execute block for the pd4 core: registers the fetched instruction and PC, splits the instruction into fields and a sign-extended immediate, generates datapath control, and computes the ALU result and branch decision from register-file read data. It sits between fetch/instruction memory and the data memory/writeback logic.

## Interface
- AWIDTH, 32, address/PC width
- DWIDTH, 32, data width
- BASEADDR, 32'h01000000, PC value held after reset
- clk  in  1  clock; all state on rising edge
- rst  in  1  reset, asynchronous, active-high
- insn_i  in  32  fetched instruction
- pc_i  in  AWIDTH  PC of insn_i
- rs1data_i / rs2data_i  in  DWIDTH  register-file read data for rs1_o / rs2_o
- pc_o, insn_o  out  AWIDTH/32  registered PC/instruction
- opcode_o 7, rd_o 5, rs1_o 5, rs2_o 5, funct3_o 3, funct7_o 7, shamt_o 5  out  raw fields of insn_o
- imm_o  out  32  sign-extended immediate
- pcsel_o, immsel_o, regwren_o, rs1sel_o, rs2sel_o, memren_o, memwren_o, jump_o, branch_o  out  1  control
- wbsel_o  out  2  0 ALU, 1 memory, 2 PC+4
- alusel_o  out  4  ALU operation
- res_o  out  DWIDTH  ALU result / target address
- brtaken_o  out  1  branch condition true

## Operation
- Fields: opcode[6:0], rd[11:7], funct3[14:12], rs1[19:15], rs2[24:20], funct7[31:25], shamt[24:20]; always driven regardless of format.
- imm: I (0x03,0x13,0x67) insn[31:20]; S (0x23) {31:25,11:7}; B (0x63) {31,7,30:25,11:8,0}; U (0x37,0x17) {31:12,12'b0}; J (0x6F) {31,19:12,20,30:21,0}; sign-extend from bit 31; other opcodes imm=0.
- alusel: 0 ADD,1 SUB,2 SLL,3 SLT,4 SLTU,5 XOR,6 SRL,7 SRA,8 OR,9 AND,10 PASS_B. R-type from funct3/funct7[5]; I-type ALU same but funct7[5] only selects SRA for funct3=101 (SUB never from I-type); LUI PASS_B; all others ADD.
- Operand A = rs1sel ? pc_o : rs1data_i; operand B = rs2sel ? imm_o : rs2data_i. Shifts use B[4:0]; SLT signed, SLTU unsigned.
- Control per opcode (regwren/memren/memwren/wbsel/rs1sel/rs2sel/jump/branch): R 1/0/0/0/0/0/0/0; I-ALU 1/0/0/0/0/1; LOAD 1/1/0/1/0/1; STORE 0/0/1/-/0/1; BRANCH 0/0/0/-/1/1/0/1; JAL 1/0/0/2/1/1/1/0; JALR 1/0/0/2/0/1/1/0; LUI 1/0/0/0/-/1; AUIPC 1/0/0/0/1/1. immsel=1 for every non-R recognised opcode.
- JALR: res_o = (rs1+imm) & ~1.
- brtaken_o only for opcode 0x63: funct3 000 BEQ, 001 BNE, 100 BLT, 101 BGE, 110 BLTU, 111 BGEU on rs1data_i vs rs2data_i; funct3 010/011 -> 0. Else 0.
- pcsel_o = jump_o | (branch_o & brtaken_o).
- Unrecognised opcode (incl. SYSTEM 0x73): all enables, jump, branch, pcsel, immsel = 0; alusel ADD; res_o = 0.

## Timing
- insn_o/pc_o registered: capture insn_i/pc_i every rising edge; one-cycle latency, no stall/enable.
- Reset (async assert, sync-to-clock release): insn_o = 32'h00000013 (NOP), pc_o = BASEADDR. During reset all outputs reflect NOP: opcode 0x13, rd 0, imm 0, regwren 1 (x0), alusel ADD, res_o = rs1data_i, brtaken/pcsel 0.
- Everything downstream of insn_o/pc_o is combinational; res_o/brtaken_o follow rs*data_i within the same cycle.
- Reset mid-stream discards the held instruction immediately.

## Configuration
- ILLEGAL_INSN_DETECT_EN defined: extra port illegal_o (out, 1) = 1 for unrecognised opcode, for funct3 010/011 on BRANCH, or nonzero funct7 other than 0x20 (SUB/SRA) in R-type; 0 under reset. Undefined: port absent, decoding otherwise identical.

## Test plan
- Reset asserted -> insn_o=0x00000013, pc_o=0x01000000, brtaken_o=0, pcsel_o=0.
- insn 0x00500093 (addi x1,x0,5), rs1data=0 -> next cycle rd=1, imm=5, regwren=1, res_o=5.
- insn 0x40208133 (sub x2,x1,x2), rs1=7, rs2=9 -> alusel=1, res_o=0xFFFFFFFE.
- insn 0xFE208EE3 (beq x1,x2,-4), pc=0x01000010, rs1=rs2=3 -> imm=0xFFFFFFFC, res_o=0x0100000C, brtaken=1, pcsel=1; rs2=4 -> pcsel=0.
- insn 0x00008067 (jalr x0,0(x1)), rs1=0x01000021 -> res_o=0x01000020, jump=1, wbsel=2, pcsel=1.
- insn 0x00000073 (ecall) -> regwren/memwren/memren/pcsel=0, res_o=0; with macro illegal_o=1.
